// File: rtl/boot_sequencer_if.sv
// rtl/boot_sequencer_if.sv - host/program-memory bus bundle for the boot sequencer
interface boot_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 7,
    parameter int CYC_WIDTH  = 16
);
    logic                  start;
    logic                  abort;
    logic [ADD_WIDTH:0]    load_len;
    logic [CYC_WIDTH-1:0]  run_cycles;
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] byte_in;
    logic                  byte_ready;
    logic                  pm_wr_en;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic [DATA_WIDTH-1:0] pm_wr_data;
    logic                  cpu_rst;
    logic                  busy;
    logic                  done;
    logic                  err;

    // Host side: issues commands and program bytes, observes status and writes.
    modport master (
        output start, abort, load_len, run_cycles, byte_valid, byte_in,
        input  byte_ready, pm_wr_en, pm_addr, pm_wr_data, cpu_rst, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, abort, load_len, run_cycles, byte_valid, byte_in,
        output byte_ready, pm_wr_en, pm_addr, pm_wr_data, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads a program image byte by byte, then runs the CPU for a cycle budget
module boot_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 7,
    parameter int CYC_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    boot_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_HALT} state_t;

    localparam logic [ADD_WIDTH:0] MAX_LEN = {1'b1, {ADD_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADD_WIDTH:0]    len_q, len_d;
    logic [ADD_WIDTH:0]    cnt_q, cnt_d;
    logic [CYC_WIDTH-1:0]  run_q, run_d;
    logic [CYC_WIDTH-1:0]  budget_q, budget_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  pm_wr_en_q, pm_wr_en_d;
    logic [ADD_WIDTH-1:0]  pm_addr_q, pm_addr_d;
    logic [DATA_WIDTH-1:0] pm_wr_data_q, pm_wr_data_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic legal_len;
    logic accept;
    logic in_session;

    assign legal_len  = (bus.load_len != '0) && (bus.load_len <= MAX_LEN);
    assign accept     = bus.byte_valid && byte_ready_q;
    assign in_session = (state_q == S_LOAD) || (state_q == S_ARM) || (state_q == S_RUN);

    // Next-state and next-output computation; outputs are produced together with the state they describe.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        run_d        = run_q;
        budget_d     = budget_q;
        byte_ready_d = byte_ready_q;
        pm_wr_en_d   = 1'b0;
        pm_addr_d    = pm_addr_q;
        pm_wr_data_d = pm_wr_data_q;
        cpu_rst_d    = cpu_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = 1'b0;

        if (in_session && bus.abort) begin
            // Abort drops any byte offered in the same cycle, so no write follows.
            state_d      = S_IDLE;
            byte_ready_d = 1'b0;
            cpu_rst_d    = 1'b1;
            busy_d       = 1'b0;
            done_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    // Abort alongside start cancels the start outright.
                    if (bus.start && !bus.abort) begin
                        if (legal_len) begin
                            state_d      = S_LOAD;
                            len_d        = bus.load_len;
                            run_d        = bus.run_cycles;
                            cnt_d        = '0;
                            pm_addr_d    = '0;
                            byte_ready_d = 1'b1;
                            busy_d       = 1'b1;
                            done_d       = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        pm_wr_en_d   = 1'b1;
                        pm_addr_d    = cnt_q[ADD_WIDTH-1:0];
                        pm_wr_data_d = bus.byte_in;
                        cnt_d        = cnt_q + 1'b1;
                        // cnt is one bit wider than the address so a full-memory load never wraps.
                        if (cnt_q == len_q - 1'b1) begin
                            state_d      = S_ARM;
                            byte_ready_d = 1'b0;
                        end
                    end
                end
                S_ARM: begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                    budget_d  = run_q;
                end
                S_RUN: begin
                    // A zero budget means run until aborted.
                    if (run_q != '0) begin
                        budget_d = budget_q - 1'b1;
                        if (budget_q == CYC_WIDTH'(1)) begin
                            state_d   = S_HALT;
                            cpu_rst_d = 1'b1;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    byte_ready_d = 1'b0;
                    cpu_rst_d    = 1'b1;
                    busy_d       = 1'b0;
                    done_d       = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            run_q        <= '0;
            budget_q     <= '0;
            byte_ready_q <= 1'b0;
            pm_wr_en_q   <= 1'b0;
            pm_addr_q    <= '0;
            pm_wr_data_q <= '0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            budget_q     <= budget_d;
            byte_ready_q <= byte_ready_d;
            pm_wr_en_q   <= pm_wr_en_d;
            pm_addr_q    <= pm_addr_d;
            pm_wr_data_q <= pm_wr_data_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.pm_wr_en   = pm_wr_en_q;
    assign bus.pm_addr    = pm_addr_q;
    assign bus.pm_wr_data = pm_wr_data_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule
